// File: rtl/aec_pkg.sv
// Shared definitions for the arithmetic-expression calculator and its ASCII link.
// Holds the operator character codes, the legal-character check and the tx state enum.
package aec_pkg;

  localparam logic [7:0] LEFT_BRACK  = 8'd40;
  localparam logic [7:0] RIGHT_BRACK = 8'd41;
  localparam logic [7:0] MULTIPLY    = 8'd42;
  localparam logic [7:0] ADDITION    = 8'd43;
  localparam logic [7:0] SUBTRACTION = 8'd45;
  localparam logic [7:0] EQUAL       = 8'd61;

  localparam logic [7:0] DIGIT_LO    = 8'd48;
  localparam logic [7:0] DIGIT_HI    = 8'd57;
  localparam logic [7:0] HEX_LO      = 8'd97;
  localparam logic [7:0] HEX_HI      = 8'd102;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } tx_state_e;

  // Digits, lower-case hex letters, brackets, the three operators and '='.
  function automatic logic is_legal(input logic [7:0] ch);
    logic ok;
    ok = ((ch >= DIGIT_LO) && (ch <= DIGIT_HI)) ||
         ((ch >= HEX_LO) && (ch <= HEX_HI)) ||
         (ch == LEFT_BRACK) || (ch == RIGHT_BRACK) ||
         (ch == MULTIPLY) || (ch == ADDITION) ||
         (ch == SUBTRACTION) || (ch == EQUAL);
    return ok;
  endfunction

endpackage

// File: rtl/aec_expr_tx_if.sv
// Host-write, calculator-link and status signals of aec_expr_tx.
// exp_result/mismatch exist only when AEC_TX_CHECK_EN is defined.
interface aec_expr_tx_if;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       start;
  logic       busy;
  logic       tx_ready;
  logic [7:0] tx_ascii;
  logic       rx_valid;
  logic [6:0] rx_result;
  logic       done;
  logic [6:0] result;
  logic       timeout;
  logic       bad_char;
`ifdef AEC_TX_CHECK_EN
  logic [6:0] exp_result;
  logic       mismatch;

  modport master (
    output wr_en, wr_data, start, rx_valid, rx_result, exp_result,
    input  wr_full, busy, tx_ready, tx_ascii, done, result, timeout, bad_char, mismatch
  );

  modport slave (
    input  wr_en, wr_data, start, rx_valid, rx_result, exp_result,
    output wr_full, busy, tx_ready, tx_ascii, done, result, timeout, bad_char, mismatch
  );
`else
  modport master (
    output wr_en, wr_data, start, rx_valid, rx_result,
    input  wr_full, busy, tx_ready, tx_ascii, done, result, timeout, bad_char
  );

  modport slave (
    input  wr_en, wr_data, start, rx_valid, rx_result,
    output wr_full, busy, tx_ready, tx_ascii, done, result, timeout, bad_char
  );
`endif

endinterface

// File: rtl/aec_tx_buf.sv
// Expression buffer: DEPTH x 8 write-once register file with write pointer,
// registered full flag and combinational read port.
module aec_tx_buf #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic                     full
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;

  // Next-state: append at the write pointer unless full; clear rewinds the pointer.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (wr_en && !full_q) begin
      mem_d[cnt_q[AW-1:0]] = wr_data;
      cnt_d                = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    full_d = (cnt_d == CNT_FULL);
  end

  // Storage, pointer and full flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      cnt_q  <= {CNT_W{1'b0}};
      full_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign full    = full_q;

endmodule

// File: rtl/aec_expr_tx.sv
// Transmit driver for the calculator ASCII link: buffers a host expression, streams it on
// start, then captures the result or times out. Optional result check: AEC_TX_CHECK_EN.
module aec_expr_tx
  import aec_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  aec_expr_tx_if.slave bus
);

  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

  tx_state_e     state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          eq_seen_q, eq_seen_d;
  logic          bad_char_q, bad_char_d;
  logic          tx_ready_q, tx_ready_d;
  logic [7:0]    tx_ascii_q, tx_ascii_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [6:0]    result_q, result_d;
  logic          timeout_q, timeout_d;
`ifdef AEC_TX_CHECK_EN
  logic          mismatch_q, mismatch_d;
`endif

  logic          buf_wr_s;
  logic          buf_clr_s;
  logic          buf_full_s;
  logic [7:0]    buf_rd_data_s;
  logic [7:0]    cnt_inc_s;

  assign cnt_inc_s = cnt_q + 8'd1;

  aec_tx_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (buf_clr_s),
    .wr_en  (buf_wr_s),
    .wr_data(bus.wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(buf_rd_data_s),
    .full   (buf_full_s)
  );

  // Transaction FSM next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    eq_seen_d  = eq_seen_q;
    bad_char_d = bad_char_q;
    tx_ready_d = tx_ready_q;
    tx_ascii_d = tx_ascii_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    timeout_d  = timeout_q;
`ifdef AEC_TX_CHECK_EN
    mismatch_d = mismatch_q;
`endif
    buf_wr_s   = 1'b0;
    buf_clr_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.wr_en && !is_legal(bus.wr_data)) begin
          bad_char_d = 1'b1;
        end else if (bus.wr_en && !buf_full_s && !eq_seen_q) begin
          buf_wr_s  = 1'b1;
          eq_seen_d = (bus.wr_data == EQUAL);
        end else begin
          buf_wr_s = 1'b0;
        end
        // rd_ptr_q is zero here, so the first character is presented on the very next cycle.
        if (bus.start && eq_seen_q) begin
          state_d    = SEND;
          tx_ready_d = 1'b1;
          tx_ascii_d = buf_rd_data_s;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (tx_ascii_q == EQUAL) begin
          state_d    = WAIT_RES;
          tx_ready_d = 1'b0;
          tx_ascii_d = 8'd0;
          rd_ptr_d   = {AW{1'b0}};
          cnt_d      = 8'd0;
        end else begin
          tx_ready_d = 1'b1;
          tx_ascii_d = buf_rd_data_s;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
        end
      end

      WAIT_RES: begin
        cnt_d = cnt_inc_s;
        if (bus.rx_valid) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          result_d   = bus.rx_result;
          timeout_d  = 1'b0;
`ifdef AEC_TX_CHECK_EN
          mismatch_d = (bus.rx_result != bus.exp_result);
`endif
        end else if (cnt_inc_s == TIMEOUT_C) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          result_d   = 7'd0;
          timeout_d  = 1'b1;
`ifdef AEC_TX_CHECK_EN
          mismatch_d = 1'b1;
`endif
        end else begin
          state_d = WAIT_RES;
        end
      end

      DONE: begin
        state_d    = IDLE;
        buf_clr_s  = 1'b1;
        eq_seen_d  = 1'b0;
        bad_char_d = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        tx_ready_d = 1'b0;
        tx_ascii_d = 8'd0;
        busy_d     = 1'b0;
        rd_ptr_d   = {AW{1'b0}};
      end
    endcase
  end

  // FSM and output registers; reset also discards any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= {AW{1'b0}};
      cnt_q      <= 8'd0;
      eq_seen_q  <= 1'b0;
      bad_char_q <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_ascii_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 7'd0;
      timeout_q  <= 1'b0;
`ifdef AEC_TX_CHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      eq_seen_q  <= eq_seen_d;
      bad_char_q <= bad_char_d;
      tx_ready_q <= tx_ready_d;
      tx_ascii_q <= tx_ascii_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
`ifdef AEC_TX_CHECK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign bus.wr_full  = buf_full_s;
  assign bus.busy     = busy_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_ascii = tx_ascii_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.timeout  = timeout_q;
  assign bus.bad_char = bad_char_q;
`ifdef AEC_TX_CHECK_EN
  assign bus.mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_aec_expr_tx.sv
// Directed bench for aec_expr_tx (TIMEOUT=20); the check-port test runs only
// when AEC_TX_CHECK_EN is defined.
module tb_aec_expr_tx;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] seen [$];
  int         first_ofs;

  aec_expr_tx_if bus ();

  aec_expr_tx #(
    .DEPTH  (16),
    .TIMEOUT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic string seen_str();
    string r = "";
    foreach (seen[i]) r = {r, $sformatf("%c", seen[i])};
    return r;
  endfunction

  // Called at a negedge; each character is sampled on the following posedge.
  task automatic write_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = s[i];
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  // Pulses start and records the contiguous tx_ready run; returns at the negedge after it.
  task automatic collect();
    seen.delete();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    first_ofs = 1;
    while (!bus.tx_ready && first_ofs < 40) begin
      @(negedge clk);
      first_ofs++;
    end
    while (bus.tx_ready && seen.size() < 40) begin
      seen.push_back(bus.tx_ascii);
      @(negedge clk);
    end
  endtask

  task automatic respond(input int delay, input logic [6:0] val);
    repeat (delay) @(negedge clk);
    bus.rx_valid  = 1'b1;
    bus.rx_result = val;
    @(negedge clk);
    bus.rx_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready got %0b exp 0", bus.tx_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.tx_ascii !== 8'd0) begin n_fail++; $display("FAIL rst_tx_ascii got %0d exp 0", bus.tx_ascii); end
    n_checks++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %0b exp 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0)     begin n_fail++; $display("FAIL rst_done got %0b exp 0", bus.done); end
    n_checks++; if (bus.result !== 7'd0)   begin n_fail++; $display("FAIL rst_result got %0d exp 0", bus.result); end
    n_checks++; if (bus.timeout !== 1'b0)  begin n_fail++; $display("FAIL rst_timeout got %0b exp 0", bus.timeout); end
    n_checks++; if (bus.bad_char !== 1'b0) begin n_fail++; $display("FAIL rst_bad_char got %0b exp 0", bus.bad_char); end
    n_checks++; if (bus.wr_full !== 1'b0)  begin n_fail++; $display("FAIL rst_wr_full got %0b exp 0", bus.wr_full); end
  endtask

  task automatic test_basic();
    write_str("3+4=");
    collect();
    n_checks++; if (first_ofs !== 1)        begin n_fail++; $display("FAIL basic_latency got %0d exp 1", first_ofs); end
    n_checks++; if (seen_str() != "3+4=")   begin n_fail++; $display("FAIL basic_stream got '%s' exp '3+4='", seen_str()); end
    n_checks++; if (bus.busy !== 1'b1)      begin n_fail++; $display("FAIL basic_busy_wait got %0b exp 1", bus.busy); end
    respond(2, 7'd7);
    n_checks++; if (bus.done !== 1'b1)      begin n_fail++; $display("FAIL basic_done got %0b exp 1", bus.done); end
    n_checks++; if (bus.result !== 7'd7)    begin n_fail++; $display("FAIL basic_result got %0d exp 7", bus.result); end
    n_checks++; if (bus.timeout !== 1'b0)   begin n_fail++; $display("FAIL basic_timeout got %0b exp 0", bus.timeout); end
    n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL basic_busy_done got %0b exp 0", bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0)      begin n_fail++; $display("FAIL basic_done_pulse got %0b exp 0", bus.done); end
    n_checks++; if (bus.result !== 7'd7)    begin n_fail++; $display("FAIL basic_result_hold got %0d exp 7", bus.result); end
  endtask

  task automatic test_timeout();
    int w;
    write_str("(a*2)=");
    collect();
    n_checks++; if (seen_str() != "(a*2)=") begin n_fail++; $display("FAIL to_stream got '%s' exp '(a*2)='", seen_str()); end
    // collect() returns in the first WAIT_RES cycle; count WAIT_RES cycles before done.
    w = 0;
    while (!bus.done && w < 300) begin
      @(negedge clk);
      w++;
    end
    n_checks++; if (w !== 20)               begin n_fail++; $display("FAIL to_wait_cycles got %0d exp 20", w); end
    n_checks++; if (bus.result !== 7'd0)    begin n_fail++; $display("FAIL to_result got %0d exp 0", bus.result); end
    n_checks++; if (bus.timeout !== 1'b1)   begin n_fail++; $display("FAIL to_timeout got %0b exp 1", bus.timeout); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0)      begin n_fail++; $display("FAIL to_done_pulse got %0b exp 0", bus.done); end
    n_checks++; if (bus.timeout !== 1'b1)   begin n_fail++; $display("FAIL to_timeout_hold got %0b exp 1", bus.timeout); end
  endtask

  task automatic test_bad_char();
    write_str("3");
    n_checks++; if (bus.bad_char !== 1'b0)  begin n_fail++; $display("FAIL bc_before got %0b exp 0", bus.bad_char); end
    write_str("x");
    n_checks++; if (bus.bad_char !== 1'b1)  begin n_fail++; $display("FAIL bc_set got %0b exp 1", bus.bad_char); end
    write_str("+1=");
    collect();
    n_checks++; if (seen_str() != "3+1=")   begin n_fail++; $display("FAIL bc_stream got '%s' exp '3+1='", seen_str()); end
    respond(0, 7'd4);
    n_checks++; if (bus.done !== 1'b1)      begin n_fail++; $display("FAIL bc_done got %0b exp 1", bus.done); end
    n_checks++; if (bus.result !== 7'd4)    begin n_fail++; $display("FAIL bc_result got %0d exp 4", bus.result); end
    n_checks++; if (bus.timeout !== 1'b0)   begin n_fail++; $display("FAIL bc_timeout got %0b exp 0", bus.timeout); end
    @(negedge clk);
    n_checks++; if (bus.bad_char !== 1'b0)  begin n_fail++; $display("FAIL bc_cleared got %0b exp 0", bus.bad_char); end
  endtask

  task automatic test_full();
    write_str("1+2+3+4+5+6+7+8");
    n_checks++; if (bus.wr_full !== 1'b0)   begin n_fail++; $display("FAIL full_at15 got %0b exp 0", bus.wr_full); end
    write_str("=");
    n_checks++; if (bus.wr_full !== 1'b1)   begin n_fail++; $display("FAIL full_at16 got %0b exp 1", bus.wr_full); end
    write_str("9");
    n_checks++; if (bus.bad_char !== 1'b0)  begin n_fail++; $display("FAIL full_drop_bad got %0b exp 0", bus.bad_char); end
    collect();
    n_checks++; if (seen.size() !== 16)     begin n_fail++; $display("FAIL full_count got %0d exp 16", seen.size()); end
    n_checks++; if (seen_str() != "1+2+3+4+5+6+7+8=") begin n_fail++; $display("FAIL full_stream got '%s' exp '1+2+3+4+5+6+7+8='", seen_str()); end
    respond(1, 7'd36);
    n_checks++; if (bus.result !== 7'd36)   begin n_fail++; $display("FAIL full_result got %0d exp 36", bus.result); end
    @(negedge clk);
    n_checks++; if (bus.wr_full !== 1'b0)   begin n_fail++; $display("FAIL full_cleared got %0b exp 0", bus.wr_full); end
  endtask

  task automatic test_mid_reset();
    logic activity;
    write_str("5-2=");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.tx_ready !== 1'b1)  begin n_fail++; $display("FAIL mr_first_send got %0b exp 1", bus.tx_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.tx_ready !== 1'b0)  begin n_fail++; $display("FAIL mr_tx_ready_now got %0b exp 0", bus.tx_ready); end
    @(negedge clk);
    n_checks++; if (bus.tx_ready !== 1'b0)  begin n_fail++; $display("FAIL mr_tx_ready got %0b exp 0", bus.tx_ready); end
    n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL mr_busy got %0b exp 0", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    activity = 1'b0;
    repeat (6) begin
      if (bus.tx_ready || bus.busy) activity = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (activity !== 1'b0)      begin n_fail++; $display("FAIL mr_start_ignored got %0b exp 0", activity); end
  endtask

`ifdef AEC_TX_CHECK_EN
  task automatic test_check();
    bus.exp_result = 7'd6;
    write_str("2*3=");
    collect();
    respond(0, 7'd5);
    n_checks++; if (bus.mismatch !== 1'b1)  begin n_fail++; $display("FAIL chk_mismatch got %0b exp 1", bus.mismatch); end
    @(negedge clk);
    write_str("2*3=");
    collect();
    respond(0, 7'd6);
    n_checks++; if (bus.mismatch !== 1'b0)  begin n_fail++; $display("FAIL chk_match got %0b exp 0", bus.mismatch); end
    n_checks++; if (bus.result !== 7'd6)    begin n_fail++; $display("FAIL chk_result got %0d exp 6", bus.result); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'd0;
    bus.start     = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_result = 7'd0;
`ifdef AEC_TX_CHECK_EN
    bus.exp_result = 7'd0;
`endif
    test_reset();
    test_basic();
    test_timeout();
    test_bad_char();
    test_full();
    test_mid_reset();
`ifdef AEC_TX_CHECK_EN
    test_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
